// File: rtl/vector_stream_packer_pkg.sv
// Shared definitions for the vector stream packer: word width, FSM states,
// lane slice macro and length clamp helper.
`ifndef VSP_LANE
`define VSP_LANE(k) (32*(k)) +: 32
`endif

package vector_stream_packer_pkg;

    localparam int unsigned FP_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Effective vector length: requested count saturated at the lane count.
    function automatic logic [FP_W-1:0] clamp_len(input logic [FP_W-1:0] req,
                                                  input int unsigned   lanes);
        logic [FP_W-1:0] cap;
        cap = FP_W'(lanes);
        return (req > cap) ? cap : req;
    endfunction

endpackage

// File: rtl/vector_stream_packer.sv
// Packs a serial stream of 32-bit FP elements into an LBUF-lane vector and
// presents it with a valid/ack handshake.
module vector_stream_packer
    import vector_stream_packer_pkg::*;
#(
    parameter int unsigned LBUF = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [FP_W-1:0]      l,
    input  logic [FP_W-1:0]      in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [FP_W*LBUF-1:0] vec,
    output logic                 vec_valid,
    input  logic                 vec_ack,
    output logic [FP_W-1:0]      len,
    output logic                 busy
);

    localparam int unsigned VEC_W = FP_W * LBUF;
    localparam int unsigned IDX_W = $clog2(LBUF + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FP_W-1:0]    len_q, len_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               in_ready_q, in_ready_d;
    logic               vec_valid_q, vec_valid_d;
    logic               busy_q, busy_d;
    logic [FP_W-1:0]    start_len;
    logic               last_elem;

    assign start_len = clamp_len(l, LBUF);
    assign last_elem = (FP_W'(idx_q) == (len_q - FP_W'(1)));

    // Next-state, lane-write decode and registered-output precompute.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        vec_d   = vec_q;

        if (start) begin
            // Start always wins: clears any partial or held vector.
            vec_d   = '0;
            idx_d   = '0;
            len_d   = start_len;
            state_d = (start_len == '0) ? ST_HOLD : ST_FILL;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < LBUF; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                vec_d[`VSP_LANE(k)] = in_data;
                            end
                        end
                        if (last_elem) begin
                            state_d = ST_HOLD;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (vec_ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end

        in_ready_d  = (state_d == ST_FILL);
        vec_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            vec_q       <= '0;
            in_ready_q  <= 1'b0;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            vec_q       <= vec_d;
            in_ready_q  <= in_ready_d;
            vec_valid_q <= vec_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign vec_valid = vec_valid_q;
    assign busy      = busy_q;
    assign len       = len_q;
    assign vec       = vec_q;

endmodule

// File: tb/tb_vector_stream_packer.sv
// Self-checking bench for vector_stream_packer (LBUF=4): directed plan steps
// plus randomized transfers against a transaction-level model.
module tb_vector_stream_packer;

    localparam int unsigned LB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [31:0]     l = '0;
    logic [31:0]     in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [32*LB-1:0] vec;
    logic            vec_valid;
    logic            vec_ack = 1'b0;
    logic [31:0]     len;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: element list of the vector being built, its length and phase.
    logic [31:0] m_vec [LB];
    int unsigned m_len = 0;
    int unsigned m_cnt = 0;
    bit          m_fill = 0;
    bit          m_hold = 0;

    vector_stream_packer #(.LBUF(LB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .l(l),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .vec(vec), .vec_valid(vec_valid), .vec_ack(vec_ack),
        .len(len), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < int'(LB); k++) v[32*k +: 32] = m_vec[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < int'(LB); k++) m_vec[k] = '0;
        m_len = 0; m_cnt = 0; m_fill = 0; m_hold = 0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ":vec"},       128'(vec),       model_vec());
        chk({where, ":vec_valid"}, 128'(vec_valid), 128'(m_hold));
        chk({where, ":busy"},      128'(busy),      128'(m_fill | m_hold));
        chk({where, ":len"},       128'(len),       128'(m_len));
        chk({where, ":in_ready"},  128'(in_ready),  128'(m_fill));
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic cycle(input bit st, input logic [31:0] li, input bit v,
                         input logic [31:0] d, input bit ack);
        start = st; l = li; in_valid = v; in_data = d; vec_ack = ack;
        chk("in_ready_pre", 128'(in_ready), 128'(m_fill));
        if (st) begin
            for (int k = 0; k < int'(LB); k++) m_vec[k] = '0;
            m_cnt  = 0;
            m_len  = (li > 32'(LB)) ? LB : li;
            m_fill = (m_len != 0);
            m_hold = (m_len == 0);
        end else if (m_fill && v) begin
            m_vec[m_cnt] = d;
            m_cnt++;
            if (m_cnt == m_len) begin
                m_fill = 0;
                m_hold = 1;
            end
        end else if (m_hold && ack) begin
            m_hold = 0;
        end
        @(posedge clk);
        #1;
        start = 0; in_valid = 0; vec_ack = 0;
        check_outputs("post");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 32'd0, 0, 32'd0, 0);
    endtask

    initial begin
        logic [31:0] rl;
        int          guard;

        model_reset();
        #1;
        check_outputs("reset");
        #3 rst_n = 1'b1;
        idle(2);

        // 1. basic fill
        cycle(1, 32'd3, 0, 32'd0, 0);
        cycle(0, 32'd0, 1, 32'h3F800000, 0);
        cycle(0, 32'd0, 1, 32'h40000000, 0);
        cycle(0, 32'd0, 1, 32'h40400000, 0);
        chk("t1_vec", 128'(vec), {32'h0, 32'h40400000, 32'h40000000, 32'h3F800000});
        chk("t1_len", 128'(len), 128'd3);
        chk("t1_vld", 128'(vec_valid), 128'd1);
        cycle(0, 32'd0, 1, 32'hDEAD0000, 0);
        cycle(0, 32'd0, 0, 32'd0, 1);
        chk("t1_ack_busy", 128'(busy), 128'd0);

        // 2. backpressure gaps
        cycle(1, 32'd4, 0, 32'd0, 0);
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 32'd0, 1, 32'(i), 0);
            if (i < 4) cycle(0, 32'd0, 0, 32'hFFFFFFFF, 0);
        end
        chk("t2_vec", 128'(vec), {32'd4, 32'd3, 32'd2, 32'd1});
        cycle(0, 32'd0, 0, 32'd0, 1);

        // 3. clamp and zero length
        cycle(1, 32'd9, 0, 32'd0, 0);
        chk("t3_len_clamp", 128'(len), 128'd4);
        for (int i = 0; i < 4; i++) cycle(0, 32'd0, 1, 32'h100 + 32'(i), 0);
        chk("t3_hold", 128'(vec_valid), 128'd1);
        cycle(0, 32'd0, 0, 32'd0, 1);
        cycle(1, 32'd0, 1, 32'h55, 0);
        chk("t3_zero_vld", 128'(vec_valid), 128'd1);
        chk("t3_zero_vec", 128'(vec), 128'd0);
        cycle(0, 32'd0, 1, 32'h66, 1);

        // 4. abort and restart
        cycle(1, 32'd4, 0, 32'd0, 0);
        cycle(0, 32'd0, 1, 32'hAA, 0);
        cycle(0, 32'd0, 1, 32'hBB, 0);
        cycle(1, 32'd2, 0, 32'd0, 0);
        cycle(0, 32'd0, 1, 32'hCC, 0);
        cycle(0, 32'd0, 1, 32'hDD, 0);
        chk("t4_vec", 128'(vec), {32'h0, 32'h0, 32'hDD, 32'hCC});
        chk("t4_len", 128'(len), 128'd2);

        // 5. simultaneous events: ack+start in HOLD, start+element in FILL, ack in IDLE
        cycle(1, 32'd2, 0, 32'd0, 1);
        chk("t5_restart_fill", 128'(in_ready), 128'd1);
        cycle(1, 32'd2, 1, 32'hEE, 0);
        chk("t5_elem_dropped", 128'(vec), 128'd0);
        cycle(0, 32'd0, 1, 32'h11, 0);
        cycle(0, 32'd0, 1, 32'h22, 0);
        cycle(0, 32'd0, 0, 32'd0, 1);
        cycle(0, 32'd0, 0, 32'd0, 1);
        chk("t5_idle_ack_vec", 128'(vec), {32'h0, 32'h0, 32'h22, 32'h11});

        // 6. async reset mid-FILL
        cycle(1, 32'd3, 0, 32'd0, 0);
        cycle(0, 32'd0, 1, 32'h77, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(negedge clk) rst_n = 1'b1;
        #1;
        cycle(1, 32'd1, 0, 32'd0, 0);
        cycle(0, 32'd0, 1, 32'h3F800000, 0);
        chk("t6_after_vec", 128'(vec), 128'h3F800000);
        cycle(0, 32'd0, 0, 32'd0, 1);

        // Randomized transfers with gaps, huge lengths, aborts and ack delays
        for (int t = 0; t < 40; t++) begin
            rl = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 6));
            cycle(1, rl, 0, 32'd0, 0);
            guard = 0;
            while (m_fill && guard < 64) begin
                if ($urandom_range(0, 15) == 0)
                    cycle(1, 32'($urandom_range(0, 5)), 1, $urandom, 0);
                else
                    cycle(0, 32'd0, 1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)));
                guard++;
            end
            repeat ($urandom_range(0, 2)) cycle(0, 32'd0, 1, $urandom, 0);
            cycle(0, 32'd0, 0, 32'd0, 1);
            if ($urandom_range(0, 3) == 0) cycle(0, 32'd0, 1, $urandom, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
